// File: rtl/treeval_ctrl.sv
// Command sequencer for treeval: host commands become one-cycle write strobes or a start/wait/result run.
// Optional build macro TREEVAL_CTRL_CHECK_EN: drop out-of-range writes and RUN without a valid node count.
module treeval_ctrl #(
    parameter int W_ADDR    = 10,
    parameter int W_N_DATA  = 12,
    parameter int W_C_DATA  = 10,
    parameter int W_REWARD  = 12,
    parameter int W_ACTION  = 3,
    parameter int START_CYC = 1,
    parameter int WAIT_MAX  = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_op_i,
    input  logic [W_ADDR-1:0]   cmd_addr_i,
    input  logic [W_N_DATA-1:0] cmd_data_i,
    output logic                mem_par_o,
    output logic                mem_rew_o,
    output logic                mem_act_o,
    output logic                mem_weight_o,
    output logic [W_ADDR-1:0]   mem_addr_o,
    output logic [W_N_DATA-1:0] mem_data_o,
    output logic                conf_nodes_o,
    output logic [W_C_DATA-1:0] conf_data_o,
    output logic                tv_start_o,
    input  logic                exp_change_i,
    input  logic [W_REWARD-1:0] exp_i,
    input  logic [W_ACTION-1:0] act_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [W_REWARD-1:0] res_exp_o,
    output logic [W_ACTION-1:0] res_act_o,
    output logic                res_tmo_o,
    output logic                res_err_o
);
    localparam int W_WCNT = $clog2(WAIT_MAX + 1);
    localparam int W_SCNT = $clog2(START_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESULT} state_e;

    state_e              state_q, state_d;
    logic [W_SCNT-1:0]   start_cnt_q, start_cnt_d;
    logic [W_WCNT-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]          mem_strb_q, mem_strb_d;   // {weight, act, rew, par}
    logic                conf_strb_q, conf_strb_d;
    logic [W_ADDR-1:0]   mem_addr_q, mem_addr_d;
    logic [W_N_DATA-1:0] mem_data_q, mem_data_d;
    logic [W_C_DATA-1:0] conf_data_q, conf_data_d;
    logic                err_q, err_d;
    logic [W_REWARD-1:0] res_exp_q, res_exp_d;
    logic [W_ACTION-1:0] res_act_q, res_act_d;
    logic                res_tmo_q, res_tmo_d;
    logic                accept;
    logic                wr_ok, run_ok;
    logic [3:0]          wr_sel;

`ifdef TREEVAL_CTRL_CHECK_EN
    logic [W_C_DATA-1:0] node_cnt_q, node_cnt_d;
    logic                conf_seen_q, conf_seen_d;

    assign wr_ok  = 32'(cmd_addr_i) < 32'(node_cnt_q);
    assign run_ok = conf_seen_q && (node_cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            node_cnt_q  <= '0;
            conf_seen_q <= 1'b0;
        end else begin
            node_cnt_q  <= node_cnt_d;
            conf_seen_q <= conf_seen_d;
        end
    end

    always_comb begin
        node_cnt_d  = node_cnt_q;
        conf_seen_d = conf_seen_q;
        if (accept && cmd_op_i == 3'd0) begin
            node_cnt_d  = cmd_data_i[W_C_DATA-1:0];
            conf_seen_d = 1'b1;
        end
    end
`else
    assign wr_ok  = 1'b1;
    assign run_ok = 1'b1;
`endif

    assign cmd_ready_o = (state_q == S_IDLE) && rst_ni;
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        wr_sel = 4'b0000;
        case (cmd_op_i)
            3'd1:    wr_sel = 4'b0001;
            3'd2:    wr_sel = 4'b0010;
            3'd3:    wr_sel = 4'b0100;
            3'd4:    wr_sel = 4'b1000;
            default: wr_sel = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mem_strb_d  = '0;
        conf_strb_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
        conf_data_d = '0;
        err_d       = 1'b0;
        res_exp_d   = res_exp_q;
        res_act_d   = res_act_q;
        res_tmo_d   = res_tmo_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op_i)
                        3'd0: begin
                            conf_strb_d = 1'b1;
                            conf_data_d = cmd_data_i[W_C_DATA-1:0];
                        end
                        3'd1, 3'd2, 3'd3, 3'd4: begin
                            if (wr_ok) begin
                                mem_strb_d = wr_sel;
                                mem_addr_d = cmd_addr_i;
                                mem_data_d = cmd_data_i;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        3'd5: begin
                            if (run_ok) begin
                                state_d     = S_START;
                                start_cnt_d = '0;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_START: begin
                if (start_cnt_q == W_SCNT'(START_CYC - 1)) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // exp_change takes priority over a timeout landing in the same cycle
                if (exp_change_i || wait_cnt_q == W_WCNT'(WAIT_MAX - 1)) begin
                    state_d   = S_RESULT;
                    res_exp_d = exp_i;
                    res_act_d = act_i;
                    res_tmo_d = !exp_change_i;
                end else if (wait_cnt_q != W_WCNT'(WAIT_MAX)) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready_i) begin
                    state_d   = S_IDLE;
                    res_exp_d = '0;
                    res_act_d = '0;
                    res_tmo_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_strb_q  <= '0;
            conf_strb_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            conf_data_q <= '0;
            err_q       <= 1'b0;
            res_exp_q   <= '0;
            res_act_q   <= '0;
            res_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_strb_q  <= mem_strb_d;
            conf_strb_q <= conf_strb_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            conf_data_q <= conf_data_d;
            err_q       <= err_d;
            res_exp_q   <= res_exp_d;
            res_act_q   <= res_act_d;
            res_tmo_q   <= res_tmo_d;
        end
    end

    assign mem_par_o    = mem_strb_q[0];
    assign mem_rew_o    = mem_strb_q[1];
    assign mem_act_o    = mem_strb_q[2];
    assign mem_weight_o = mem_strb_q[3];
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign conf_nodes_o = conf_strb_q;
    assign conf_data_o  = conf_data_q;
    assign tv_start_o   = (state_q == S_START);
    assign res_valid_o  = (state_q == S_RESULT);
    assign res_exp_o    = res_exp_q;
    assign res_act_o    = res_act_q;
    assign res_tmo_o    = res_tmo_q;
    assign res_err_o    = err_q;
endmodule

// File: tb/tb_treeval_ctrl.sv
// Randomized bench for treeval_ctrl with a transaction-level expectation model; WAIT_MAX shortened to 8.
module tb_treeval_ctrl;
    localparam int WAIT_MAX = 8;
`ifdef TREEVAL_CTRL_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [11:0] cmd_data;
    logic        mem_par, mem_rew, mem_act, mem_weight;
    logic [9:0]  mem_addr;
    logic [11:0] mem_data;
    logic        conf_nodes;
    logic [9:0]  conf_data;
    logic        tv_start, exp_change;
    logic [11:0] exp_in;
    logic [2:0]  act_in;
    logic        res_valid, res_ready;
    logic [11:0] res_exp;
    logic [2:0]  res_act;
    logic        res_tmo, res_err;

    treeval_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .mem_par_o(mem_par), .mem_rew_o(mem_rew), .mem_act_o(mem_act), .mem_weight_o(mem_weight),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .conf_nodes_o(conf_nodes), .conf_data_o(conf_data),
        .tv_start_o(tv_start), .exp_change_i(exp_change), .exp_i(exp_in), .act_i(act_in),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_exp_o(res_exp), .res_act_o(res_act), .res_tmo_o(res_tmo), .res_err_o(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int unsigned node_cnt_m = 0;
    bit          conf_seen_m = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outv();
        return {conf_nodes, mem_par, mem_rew, mem_act, mem_weight, res_err, tv_start, res_valid};
    endfunction

    task automatic do_cmd(input logic [2:0] op, input logic [9:0] addr, input logic [11:0] data);
        logic [7:0]  e_v;
        logic [9:0]  e_addr, e_cdata;
        logic [11:0] e_data;
        e_v = '0; e_addr = '0; e_cdata = '0; e_data = '0;
        cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
        chk("cmd_rdy", cmd_ready, 1);
        case (op)
            3'd0: begin
                e_v = 8'h80; e_cdata = data[9:0];
                node_cnt_m = data[9:0]; conf_seen_m = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (CHK_EN && addr >= node_cnt_m) e_v = 8'h04;
                else begin
                    e_v = 8'h40 >> (op - 1); e_addr = addr; e_data = data;
                end
            end
            default: e_v = 8'h04;
        endcase
        tick();
        cmd_valid = 1'b0;
        chk("wr_strb", outv(), e_v);
        chk("wr_addr", mem_addr, e_addr);
        chk("wr_data", mem_data, e_data);
        chk("wr_cdata", conf_data, e_cdata);
    endtask

    task automatic idle_chk();
        tick();
        chk("idle_zero", {outv(), cmd_ready, mem_addr, mem_data, conf_data}, {8'h00, 1'b1, 32'h0});
    endtask

    // d: WAIT cycle index in which exp_change rises (>= WAIT_MAX means never)
    task automatic run_cmd(input int d, input bit glitch, input bit pre_rdy, input int bp_in);
        int          k_exp, k_obs, bp;
        logic [11:0] e_exp;
        logic [2:0]  e_act;
        logic        tmo_e;
        bp = pre_rdy ? 0 : bp_in;
        e_exp = '0; e_act = '0;
        cmd_op = 3'd5; cmd_addr = 10'($urandom); cmd_data = 12'($urandom); cmd_valid = 1'b1;
        chk("run_rdy", cmd_ready, 1);
        if (CHK_EN && (!conf_seen_m || node_cnt_m == 0)) begin
            tick();
            cmd_valid = 1'b0;
            chk("run_drop", outv(), 8'h04);
            return;
        end
        exp_change = glitch; res_ready = pre_rdy;
        tick();
        cmd_valid = 1'b0;
        chk("run_start", {outv(), cmd_ready}, {8'h02, 1'b0});
        tick();
        chk("wait_entry", {tv_start, res_valid}, 2'b00);
        k_exp = (d < WAIT_MAX) ? d : WAIT_MAX - 1;
        tmo_e = (d >= WAIT_MAX);
        k_obs = -1;
        for (int k = 0; k < WAIT_MAX + 4 && k_obs < 0; k++) begin
            exp_change = (k == d);
            exp_in = 12'($urandom); act_in = 3'($urandom);
            if (k == k_exp) begin e_exp = exp_in; e_act = act_in; end
            tick();
            if (res_valid) k_obs = k;
        end
        exp_change = 1'b0;
        chk("run_lat", k_obs, k_exp);
        chk("res_flds", {res_exp, res_act, res_tmo}, {e_exp, e_act, tmo_e});
        for (int i = 0; i < bp; i++) begin
            exp_in = 12'($urandom); act_in = 3'($urandom); exp_change = 1'($urandom);
            tick();
            chk("res_hold", {res_valid, cmd_ready, res_exp, res_act, res_tmo},
                {1'b1, 1'b0, e_exp, e_act, tmo_e});
        end
        exp_change = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_done", {res_valid, cmd_ready}, 2'b01);
    endtask

    task automatic reset_mid_wait();
        int seen;
        cmd_op = 3'd5; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_mid", {outv(), cmd_ready, mem_addr, mem_data, conf_data}, '0);
        rst_n = 1'b1;
        node_cnt_m = 0; conf_seen_m = 1'b0;
        #1;
        chk("rst_mid_rdy", cmd_ready, 1);
        seen = 0;
        exp_change = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid || tv_start) seen++;
        end
        exp_change = 1'b0;
        chk("rst_no_res", seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] rew_t [5] = '{12'hFF6, 12'h000, 12'h064, 12'hFCE, 12'h00A};
    logic [11:0] act_t [6] = '{12'd1, 12'd1, 12'd0, 12'd1, 12'd1, 12'd0};
    logic [11:0] wgt_t [6] = '{12'd64, 12'd64, 12'd100, 12'd64, 12'd64, 12'd127};

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        exp_change = 1'b0; exp_in = '0; act_in = '0; res_ready = 1'b0;
        tick();
        tick();
        chk("rst_out", {outv(), cmd_ready, mem_addr, mem_data, conf_data, res_exp, res_act, res_tmo}, '0);
        rst_n = 1'b1;
        #1;
        chk("rst_rdy", cmd_ready, 1);

        // seven-node tree, back-to-back
        do_cmd(3'd0, 10'd0, 12'd7);
        for (int n = 1; n <= 6; n++) do_cmd(3'd1, 10'(n), (n <= 3) ? 12'd0 : 12'd1);
        for (int n = 2; n <= 6; n++) do_cmd(3'd2, 10'(n), rew_t[n-2]);
        for (int n = 1; n <= 6; n++) do_cmd(3'd3, 10'(n), act_t[n-1]);
        for (int n = 1; n <= 6; n++) do_cmd(3'd4, 10'(n), wgt_t[n-1]);
        idle_chk();
        run_cmd(2, 1'b1, 1'b0, 0);
        run_cmd(1000, 1'b0, 1'b0, 5);
        run_cmd(WAIT_MAX - 1, 1'b0, 1'b1, 0);

        do_cmd(3'd0, 10'd0, 12'd7);
        do_cmd(3'd1, 10'd9, 12'h005);
        do_cmd(3'd6, 10'd0, 12'd0);
        idle_chk();
        reset_mid_wait();

        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 2) do_cmd(3'd0, 10'($urandom), 12'($urandom_range(0, 12)));
            else if (r < 7) do_cmd(3'($urandom_range(1, 4)), 10'($urandom_range(0, 15)), 12'($urandom));
            else if (r == 7) do_cmd(3'($urandom_range(6, 7)), 10'($urandom), 12'($urandom));
            else run_cmd($urandom_range(0, WAIT_MAX + 2), 1'($urandom), 1'($urandom), $urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) idle_chk();
        end
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
